pipe_stage_skid: RTL and testbench

- Parametrised, flow-controlled pipeline stage register. Successor to the fixed-width, always-advancing inter-stage latches in the CPU datapath (EX/WB class).
- Carries a data bundle plus a control bundle (regWrite, branch, immToReg, ...) from one stage to the next with a valid/ready handshake, a 2-entry skid buffer, and a synchronous flush.
- Control bits are forced to 0 whenever the stage holds a bubble, so downstream write-back can never act on stale control.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/sat_counter.sv | 35 +++
 rtl/pipe_stage_skid.sv | 130 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for flow-controlled pipeline stages.
// Provides stage occupancy states, stall counter width and EX/WB widths.
package pipe_pkg;

    // Encoding mirrors {skid_valid, main_valid}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } stage_state_t;

    localparam int unsigned STALL_CNT_W = 16;

    localparam int unsigned EXWB_DATA_W = 32;
    localparam int unsigned EXWB_CTRL_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk_i, rst_i (async high), inc_i, clear_i, count_o.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Flow-controlled pipeline stage with 2-entry skid buffer and flush.
// Ports: clk, rst (async high), flush, in_valid/in_ready/in_data/in_ctrl,
// out_valid/out_ready/out_data/out_ctrl, stall_cnt.
// PIPE_STAGE_PERF_EN builds a saturating stall counter; else stall_cnt=0.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W   = EXWB_DATA_W,
    parameter int unsigned       CTRL_W   = EXWB_CTRL_W,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [CTRL_W-1:0]      in_ctrl,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    stage_state_t state;
    logic         in_xfer;
    logic         out_xfer;

    assign in_ready = ~skid_valid_q;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_valid_q & out_ready;
    assign state    = stage_state_t'({skid_valid_q, main_valid_q});

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = RST_DATA;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_data_d  = RST_DATA;
            skid_ctrl_d  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_valid_d = 1'b1;
                        main_data_d  = in_data;
                        main_ctrl_d  = in_ctrl;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_xfer) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data;
                        skid_ctrl_d  = in_ctrl;
                    end else if (out_xfer) begin
                        // Clear ctrl so a bubble never drives enables
                        main_valid_d = 1'b0;
                        main_ctrl_d  = '0;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_data_d  = skid_data_q;
                        main_ctrl_d  = skid_ctrl_q;
                        skid_valid_d = 1'b0;
                        skid_ctrl_d  = '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= RST_DATA;
            main_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= RST_DATA;
            skid_ctrl_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;

`ifdef PIPE_STAGE_PERF_EN
    sat_counter #(
        .WIDTH(STALL_CNT_W)
    ) u_stall_cnt (
        .clk_i  (clk),
        .rst_i  (rst),
        .inc_i  (main_valid_q & ~out_ready),
        .clear_i(1'b0),
        .count_o(stall_cnt)
    );
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue-based reference model, per-cycle compare,
// directed scenarios plus randomized traffic with backpressure and flush.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [15:0]   stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W  (DW),
        .CTRL_W  (CW),
        .RST_DATA('0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_stall;
    int          checks   = 0;
    int          failures = 0;
    bit          cmp_en   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic stage_state_t m_state();
        if (mq.size() == 0) return EMPTY;
        if (mq.size() == 1) return BUSY;
        return FULL;
    endfunction

    function automatic logic [1:0] dut_state();
        if (!out_valid) return in_ready ? EMPTY : 2'b10;
        return in_ready ? BUSY : FULL;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_stall = 0;
    endtask

    // One clock of the stage's contract: FIFO of depth 2, flush empties it
    task automatic model_step();
        bit ov;
        bit ir;
        ent_t e;
        ov = (mq.size() > 0);
        ir = (mq.size() < 2);
        if (ov && !out_ready && m_stall < 32'hFFFF) m_stall++;
        if (flush) begin
            mq.delete();
        end else begin
            if (ov && out_ready) e = mq.pop_front();
            if (in_valid && ir) begin
                e.d = in_data;
                e.c = in_ctrl;
                mq.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        tick();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("state", 64'(dut_state()), 64'(m_state()));
            chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
            if (mq.size() > 0) begin
                chk("out_data", 64'(out_data), 64'(mq[0].d));
                chk("out_ctrl", 64'(out_ctrl), 64'(mq[0].c));
            end else begin
                chk("out_ctrl_bubble", 64'(out_ctrl), 64'(0));
            end
`ifdef PIPE_STAGE_PERF_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`else
            chk("stall_cnt", 64'(stall_cnt), 64'(0));
`endif
        end
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_ctrl", 64'(out_ctrl), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_stall", 64'(stall_cnt), 64'(0));
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            in_ctrl  = 4'(i);
            tick();
            chk("stream_data", 64'(out_data), 64'(i));
            chk("stream_valid", 64'(out_valid), 64'(1));
            chk("stream_ready", 64'(in_ready), 64'(1));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", 64'(out_valid), 64'(0));

        // Backpressure fills the skid entry
        out_ready = 1'b0;
        send(32'h11, 4'h1);
        send(32'h22, 4'h2);
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_hold", 64'(out_data), 64'h11);
        tick();
        tick();
        chk("bp_stable", 64'(out_data), 64'h11);
        chk("bp_ctrl", 64'(out_ctrl), 64'h1);
        out_ready = 1'b1;
        tick();
        chk("bp_second", 64'(out_data), 64'h22);
        chk("bp_second_ctrl", 64'(out_ctrl), 64'h2);
        tick();
        chk("bp_empty", 64'(out_valid), 64'(0));

        // Flush while FULL with an offered transfer
        out_ready = 1'b0;
        send(32'h44, 4'h4);
        send(32'h55, 4'h5);
        in_valid = 1'b1;
        in_data  = 32'h33;
        in_ctrl  = 4'hF;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 64'(out_valid), 64'(0));
        chk("fl_ctrl", 64'(out_ctrl), 64'(0));
        chk("fl_data", 64'(out_data), 64'(0));
        chk("fl_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        tick();
        chk("fl_no33", 64'(out_valid), 64'(0));

        // Flush in BUSY drops a same-cycle accepted input
        out_ready = 1'b0;
        send(32'h60, 4'h6);
        in_valid = 1'b1;
        in_data  = 32'h66;
        in_ctrl  = 4'hF;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_busy_valid", 64'(out_valid), 64'(0));

        // Bubble gating
        out_ready = 1'b1;
        in_ctrl   = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bubble_ctrl", 64'(out_ctrl), 64'(0));
        end

        // Reset mid-stream while FULL
        out_ready = 1'b0;
        send(32'hA, 4'hA);
        send(32'hB, 4'hB);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("mr_valid", 64'(out_valid), 64'(0));
        chk("mr_ctrl", 64'(out_ctrl), 64'(0));
        chk("mr_ready", 64'(in_ready), 64'(1));
        chk("mr_stall", 64'(stall_cnt), 64'(0));
        tick();
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_ctrl   = 4'($urandom);
            out_ready = (i % 400 < 200) ? ($urandom_range(0, 3) != 0)
                                        : ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("rand_drained", 64'(out_valid), 64'(0));

        // Stall counter
        rst = 1'b1;
        model_reset();
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        send(32'h77, 4'h7);
`ifdef PIPE_STAGE_PERF_EN
        repeat (70000) tick();
        chk("perf_sat", 64'(stall_cnt), 64'hFFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("perf_keep", 64'(stall_cnt), 64'hFFFF);
`else
        repeat (200) tick();
        chk("perf_off", 64'(stall_cnt), 64'(0));
`endif

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
